omsp_hmac_arbiter: RTL and testbench

//  Shares the single HMAC core between N_REQ requesters: attestation/sign control, key derivation at SM enable, and others.

---
 rtl/omsp_hmac_arbiter_pkg.sv | 18 +
 rtl/omsp_hmac_arb_pick.sv | 44 ++++
 rtl/omsp_hmac_arbiter.sv | 146 ++++++++++++++
 tb/tb_omsp_hmac_arbiter.sv | 388 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/omsp_hmac_arbiter_pkg.sv
// Shared state codes and requester indices for the HMAC core arbiter.
// Round-robin arbitration is enabled by defining OMSP_HMAC_ARB_RR_EN.
package omsp_hmac_arbiter_pkg;

    // Owner/last index width; wide enough for the largest legal N_REQ (4).
    localparam int IDX_W = 2;

    localparam int HMAC_ARB_REQ_SIGN = 0;
    localparam int HMAC_ARB_REQ_KDF  = 1;

    typedef enum logic [1:0] {
        HMAC_ARB_IDLE  = 2'b00,
        HMAC_ARB_SETUP = 2'b01,
        HMAC_ARB_OWN   = 2'b10,
        HMAC_ARB_DRAIN = 2'b11
    } hmac_arb_state_e;

endpackage

// File: rtl/omsp_hmac_arb_pick.sv
// Combinational winner select for the HMAC arbiter.
// OMSP_HMAC_ARB_RR_EN selects round-robin after 'last'; otherwise lowest index wins.
module omsp_hmac_arb_pick
    import omsp_hmac_arbiter_pkg::*;
#(
    parameter int N_REQ = 2
) (
    input  logic [N_REQ-1:0] req_i,
`ifdef OMSP_HMAC_ARB_RR_EN
    input  logic [IDX_W-1:0] last_i,
`endif
    output logic [IDX_W-1:0] idx_o,
    output logic             valid_o
);

    logic [N_REQ-1:0] pool;

`ifdef OMSP_HMAC_ARB_RR_EN
    logic [N_REQ-1:0] after_mask;
    logic [N_REQ-1:0] after_req;

    // Requesters strictly above 'last' get first pick; otherwise wrap to index 0.
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_after
        assign after_mask[gi] = (IDX_W'(gi) > last_i);
    end

    assign after_req = req_i & after_mask;
    assign pool      = (|after_req) ? after_req : req_i;
`else
    assign pool = req_i;
`endif

    always_comb begin
        idx_o = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (pool[i]) begin
                idx_o = IDX_W'(i);
            end
        end
    end

    assign valid_o = |req_i;

endmodule

// File: rtl/omsp_hmac_arbiter.sv
// Transaction-locked arbiter sharing one HMAC core between N_REQ requesters.
// Define OMSP_HMAC_ARB_RR_EN for round-robin; default build is fixed priority.
module omsp_hmac_arbiter
    import omsp_hmac_arbiter_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int DW    = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [N_REQ-1:0]    req,
    input  logic [N_REQ-1:0]    req_start_cont,
    input  logic [N_REQ-1:0]    req_data_avail,
    input  logic [N_REQ-1:0]    req_data_long,
    input  logic [N_REQ*DW-1:0] req_data,
    output logic [N_REQ-1:0]    grant,
    output logic [N_REQ-1:0]    req_busy,
    input  logic                hmac_busy,
    output logic                hmac_reset,
    output logic                hmac_start_cont,
    output logic                hmac_data_avail,
    output logic                hmac_data_long,
    output logic [DW-1:0]       hmac_data,
    output logic                viol
);

    hmac_arb_state_e  state_q;
    logic [IDX_W-1:0] owner_q;
    logic [N_REQ-1:0] grant_q;
    logic             hmac_reset_q;
    logic             viol_q;
    logic             viol_d;

    logic [N_REQ-1:0] owner_oh;
    logic [N_REQ-1:0] own_sel;
    logic             own_active;
    logic             owner_released;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_valid;
    logic [N_REQ-1:0] strobe;

`ifdef OMSP_HMAC_ARB_RR_EN
    logic [IDX_W-1:0] last_q;
`endif

    omsp_hmac_arb_pick #(
        .N_REQ   (N_REQ)
    ) u_pick (
        .req_i   (req),
`ifdef OMSP_HMAC_ARB_RR_EN
        .last_i  (last_q),
`endif
        .idx_o   (pick_idx),
        .valid_o (pick_valid)
    );

    assign own_active = (state_q == HMAC_ARB_OWN);
    // Only the owner's lane is routed while in OWN; everything else reads as idle.
    assign own_sel    = own_active ? owner_oh : '0;

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_lane
        assign owner_oh[gi] = (owner_q == IDX_W'(gi));
        assign req_busy[gi] = own_sel[gi] ? hmac_busy : 1'b1;
    end

    assign owner_released = ~|(req & owner_oh);

    assign hmac_start_cont = |(req_start_cont & own_sel);
    assign hmac_data_avail = |(req_data_avail & own_sel);
    assign hmac_data_long  = |(req_data_long  & own_sel);

    always_comb begin
        hmac_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (own_sel[i]) begin
                hmac_data = hmac_data | req_data[i*DW +: DW];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= HMAC_ARB_IDLE;
            owner_q      <= IDX_W'(HMAC_ARB_REQ_SIGN);
            grant_q      <= '0;
            hmac_reset_q <= 1'b1;
`ifdef OMSP_HMAC_ARB_RR_EN
            last_q       <= IDX_W'(N_REQ - 1);
`endif
        end else begin
            case (state_q)
                HMAC_ARB_IDLE: begin
                    grant_q      <= '0;
                    hmac_reset_q <= 1'b1;
                    if (pick_valid) begin
                        owner_q      <= pick_idx;
                        hmac_reset_q <= 1'b0;
                        state_q      <= HMAC_ARB_SETUP;
                    end
                end
                HMAC_ARB_SETUP: begin
                    // Core reset was released on entry; grant lands one cycle later.
                    grant_q <= owner_oh;
                    state_q <= HMAC_ARB_OWN;
                end
                HMAC_ARB_OWN: begin
                    if (owner_released) begin
                        grant_q      <= '0;
                        hmac_reset_q <= 1'b1;
                        state_q      <= HMAC_ARB_DRAIN;
`ifdef OMSP_HMAC_ARB_RR_EN
                        last_q       <= owner_q;
`endif
                    end
                end
                HMAC_ARB_DRAIN: begin
                    if (!hmac_busy) begin
                        state_q <= HMAC_ARB_IDLE;
                    end
                end
                default: begin
                    grant_q      <= '0;
                    hmac_reset_q <= 1'b1;
                    state_q      <= HMAC_ARB_IDLE;
                end
            endcase
        end
    end

    // Any strobe from outside the current owner lane is a protocol violation.
    assign strobe = req_start_cont | req_data_avail;
    assign viol_d = viol_q | (|(strobe & ~own_sel));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            viol_q <= 1'b0;
        end else begin
            viol_q <= viol_d;
        end
    end

    assign grant      = grant_q;
    assign hmac_reset = hmac_reset_q;
    assign viol       = viol_q;

endmodule

// File: tb/tb_omsp_hmac_arbiter.sv
// Self-checking bench for omsp_hmac_arbiter against a transaction-level model.
// Build with OMSP_HMAC_ARB_RR_EN defined to check the round-robin variant.
module tb_omsp_hmac_arbiter;

    localparam int N_REQ = 2;
    localparam int DW    = 16;

    logic                clk = 1'b0;
    logic                reset_n = 1'b0;
    logic [N_REQ-1:0]    req = '0;
    logic [N_REQ-1:0]    req_start_cont = '0;
    logic [N_REQ-1:0]    req_data_avail = '0;
    logic [N_REQ-1:0]    req_data_long = '0;
    logic [N_REQ*DW-1:0] req_data = '0;
    logic [N_REQ-1:0]    grant;
    logic [N_REQ-1:0]    req_busy;
    logic                hmac_busy = 1'b0;
    logic                hmac_reset;
    logic                hmac_start_cont;
    logic                hmac_data_avail;
    logic                hmac_data_long;
    logic [DW-1:0]       hmac_data;
    logic                viol;

    int tests_run    = 0;
    int tests_failed = 0;
    int model_last   = N_REQ - 1;

    always #5 clk = ~clk;

    omsp_hmac_arbiter #(.N_REQ(N_REQ), .DW(DW)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .req             (req),
        .req_start_cont  (req_start_cont),
        .req_data_avail  (req_data_avail),
        .req_data_long   (req_data_long),
        .req_data        (req_data),
        .grant           (grant),
        .req_busy        (req_busy),
        .hmac_busy       (hmac_busy),
        .hmac_reset      (hmac_reset),
        .hmac_start_cont (hmac_start_cont),
        .hmac_data_avail (hmac_data_avail),
        .hmac_data_long  (hmac_data_long),
        .hmac_data       (hmac_data),
        .viol            (viol)
    );

    // Reference winner: round-robin after 'last', or lowest requesting index.
    function automatic int model_winner(input logic [N_REQ-1:0] r, input int last);
        int w;
        w = -1;
`ifdef OMSP_HMAC_ARB_RR_EN
        for (int k = 1; k <= N_REQ; k++) begin
            if (w < 0 && r[(last + k) % N_REQ]) w = (last + k) % N_REQ;
        end
`else
        for (int k = 0; k < N_REQ; k++) begin
            if (w < 0 && r[k]) w = k;
        end
        if (last > N_REQ) w = -1;
`endif
        return w;
    endfunction

    function automatic logic [N_REQ-1:0] onehot(input int w);
        logic [N_REQ-1:0] v;
        v = '0;
        if (w >= 0) v[w] = 1'b1;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Advances until a grant appears or the budget runs out; n = edges waited.
    task automatic wait_grant(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (grant == '0 && n < 20);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        tick();
        tick();
        tests_run++;
        if (grant !== 2'b00 || req_busy !== 2'b11 || hmac_reset !== 1'b1 || viol !== 1'b0 || hmac_data !== '0) begin
            tests_failed++;
            $display("FAIL reset_state: grant=%b busy=%b rst=%b viol=%b data=%h required 00 11 1 0 0000",
                     grant, req_busy, hmac_reset, viol, hmac_data);
        end
        reset_n = 1'b1;
        tick();
        tests_run++;
        if (grant !== 2'b00 || hmac_reset !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_idle: grant=%b rst=%b required 00 1", grant, hmac_reset);
        end
        $display("[TB] reset: grant=%b req_busy=%b hmac_reset=%b", grant, req_busy, hmac_reset);
    endtask

    task automatic test_single();
        req = 2'b01;
        tick();
        tests_run++;
        if (grant !== 2'b00 || hmac_reset !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_setup: grant=%b rst=%b required 00 0", grant, hmac_reset);
        end
        tick();
        tests_run++;
        if (grant !== 2'b01) begin
            tests_failed++;
            $display("FAIL single_grant_latency: grant=%b required 01", grant);
        end
        req_data_avail = 2'b01;
        req_data[0 +: DW] = 16'hA5A5;
        hmac_busy = 1'b0;
        #1;
        tests_run++;
        if (hmac_data !== 16'hA5A5 || hmac_data_avail !== 1'b1 || req_busy !== 2'b10) begin
            tests_failed++;
            $display("FAIL single_mux: data=%h avail=%b busy=%b required a5a5 1 10",
                     hmac_data, hmac_data_avail, req_busy);
        end
        hmac_busy = 1'b1;
        #1;
        tests_run++;
        if (req_busy !== 2'b11) begin
            tests_failed++;
            $display("FAIL single_busy_pass: busy=%b required 11", req_busy);
        end
        req = 2'b00;
        req_data_avail = 2'b00;
        hmac_busy = 1'b0;
        tick();
        tests_run++;
        if (grant !== 2'b00 || hmac_reset !== 1'b1 || hmac_data !== '0 || hmac_data_avail !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_drain: grant=%b rst=%b data=%h avail=%b required 00 1 0000 0",
                     grant, hmac_reset, hmac_data, hmac_data_avail);
        end
        tick();
        model_last = 0;
        $display("[TB] single: requester 0 served, data a5a5");
    endtask

    task automatic test_contention();
        int w, w2, w3, n;
        req = 2'b11;
        w = model_winner(req, model_last);
        wait_grant(n);
        tests_run++;
        if (grant !== onehot(w) || n != 2) begin
            tests_failed++;
            $display("FAIL contention_first: grant=%b after %0d required %b after 2", grant, n, onehot(w));
        end
        req[w] = 1'b0;
        model_last = w;
        w2 = model_winner(req, model_last);
        wait_grant(n);
        tests_run++;
        if (grant !== onehot(w2) || n != 4) begin
            tests_failed++;
            $display("FAIL contention_second: grant=%b after %0d required %b after 4", grant, n, onehot(w2));
        end
        req[w] = 1'b1;
        req[w2] = 1'b0;
        model_last = w2;
        w3 = model_winner(req, model_last);
        wait_grant(n);
        tests_run++;
        if (grant !== onehot(w3) || n != 4) begin
            tests_failed++;
            $display("FAIL contention_third: grant=%b after %0d required %b after 4", grant, n, onehot(w3));
        end
        req = 2'b00;
        model_last = w3;
        tick();
        tick();
        $display("[TB] contention: winners %0d %0d %0d", w, w2, w3);
    endtask

    task automatic test_drain_hold();
        int n;
        req = 2'b01;
        wait_grant(n);
        req = 2'b10;
        hmac_busy = 1'b1;
        model_last = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            tests_run++;
            if (grant !== 2'b00 || hmac_reset !== 1'b1) begin
                tests_failed++;
                $display("FAIL drain_hold_%0d: grant=%b rst=%b required 00 1", k, grant, hmac_reset);
            end
        end
        hmac_busy = 1'b0;
        wait_grant(n);
        tests_run++;
        if (grant !== 2'b10 || n != 3) begin
            tests_failed++;
            $display("FAIL drain_release: grant=%b after %0d required 10 after 3", grant, n);
        end
        req = 2'b00;
        model_last = 1;
        tick();
        tick();
        $display("[TB] drain_hold: requester 1 granted %0d edges after busy dropped", n);
    endtask

    task automatic test_lock();
        int n;
        req = 2'b01;
        req_data[0 +: DW] = 16'hBEEF;
        req_data[DW +: DW] = 16'h1234;
        wait_grant(n);
        req = 2'b11;
        for (int k = 0; k < 4; k++) begin
            tick();
            tests_run++;
            if (grant !== 2'b01 || req_busy[1] !== 1'b1 || hmac_data !== 16'hBEEF) begin
                tests_failed++;
                $display("FAIL lock_%0d: grant=%b busy1=%b data=%h required 01 1 beef",
                         k, grant, req_busy[1], hmac_data);
            end
        end
        req = 2'b10;
        model_last = 0;
        wait_grant(n);
        tests_run++;
        if (grant !== 2'b10 || n != 4 || hmac_data !== 16'h1234) begin
            tests_failed++;
            $display("FAIL lock_handover: grant=%b after %0d data=%h required 10 after 4 1234", grant, n, hmac_data);
        end
        req = 2'b00;
        model_last = 1;
        tick();
        tick();
        $display("[TB] lock: pending requester 1 served after release");
    endtask

    task automatic test_random();
        int w, n, hold;
        logic [N_REQ-1:0] r, exp_busy;
        logic [DW-1:0] d [N_REQ];
        logic sc, av, lg;
        for (int it = 0; it < 10; it++) begin
            r = N_REQ'($urandom_range(1, 3));
            w = model_winner(r, model_last);
            req = r;
            wait_grant(n);
            tests_run++;
            if (grant !== onehot(w) || n != 2) begin
                tests_failed++;
                $display("FAIL rand_grant_%0d: req=%b grant=%b after %0d required %b after 2",
                         it, r, grant, n, onehot(w));
            end
            for (int i = 0; i < N_REQ; i++) begin
                d[i] = DW'($urandom);
                req_data[i*DW +: DW] = d[i];
            end
            sc = 1'($urandom);
            av = 1'($urandom);
            lg = 1'($urandom);
            req_start_cont = sc ? onehot(w) : '0;
            req_data_avail = av ? onehot(w) : '0;
            req_data_long  = '1;
            req_data_long[w] = lg;
            hmac_busy = 1'($urandom);
            exp_busy = '1;
            exp_busy[w] = hmac_busy;
            #1;
            tests_run++;
            if (hmac_data !== d[w] || hmac_start_cont !== sc || hmac_data_avail !== av ||
                hmac_data_long !== lg || req_busy !== exp_busy) begin
                tests_failed++;
                $display("FAIL rand_mux_%0d: data=%h sc=%b av=%b lg=%b busy=%b required %h %b %b %b %b",
                         it, hmac_data, hmac_start_cont, hmac_data_avail, hmac_data_long, req_busy,
                         d[w], sc, av, lg, exp_busy);
            end
            hold = $urandom_range(0, 3);
            req = '0;
            req_start_cont = '0;
            req_data_avail = '0;
            req_data_long = '0;
            hmac_busy = (hold > 0);
            tick();
            for (int h = 0; h < hold; h++) tick();
            hmac_busy = 1'b0;
            tick();
            tests_run++;
            if (grant !== '0 || hmac_reset !== 1'b1 || viol !== 1'b0 || hmac_data_long !== 1'b0) begin
                tests_failed++;
                $display("FAIL rand_release_%0d: grant=%b rst=%b viol=%b long=%b required 00 1 0 0",
                         it, grant, hmac_reset, viol, hmac_data_long);
            end
            model_last = w;
            $display("[TB] random %0d: req=%b winner=%0d drain_hold=%0d", it, r, w, hold);
        end
    endtask

    task automatic test_violation();
        int n;
        req = 2'b01;
        wait_grant(n);
        tests_run++;
        if (viol !== 1'b0) begin
            tests_failed++;
            $display("FAIL viol_clean: viol=%b required 0", viol);
        end
        req_data_avail = 2'b10;
        #1;
        tests_run++;
        if (hmac_data_avail !== 1'b0) begin
            tests_failed++;
            $display("FAIL viol_isolation: hmac_data_avail=%b required 0", hmac_data_avail);
        end
        tick();
        req_data_avail = 2'b00;
        tests_run++;
        if (viol !== 1'b1) begin
            tests_failed++;
            $display("FAIL viol_set: viol=%b required 1", viol);
        end
        tick();
        tick();
        tick();
        tests_run++;
        if (viol !== 1'b1) begin
            tests_failed++;
            $display("FAIL viol_sticky: viol=%b required 1", viol);
        end
        $display("[TB] violation: viol=%b", viol);
    endtask

    task automatic test_async_reset();
        int w, n;
        // Requester 0 still owns the core from the violation scenario.
        #3;
        reset_n = 1'b0;
        #1;
        tests_run++;
        if (grant !== 2'b00 || hmac_reset !== 1'b1 || req_busy !== 2'b11 || viol !== 1'b0) begin
            tests_failed++;
            $display("FAIL async_reset: grant=%b rst=%b busy=%b viol=%b required 00 1 11 0",
                     grant, hmac_reset, req_busy, viol);
        end
        req = 2'b00;
        model_last = N_REQ - 1;
        tick();
        reset_n = 1'b1;
        tick();
        req = 2'b11;
        w = model_winner(req, model_last);
        wait_grant(n);
        tests_run++;
        if (grant !== onehot(w) || n != 2) begin
            tests_failed++;
            $display("FAIL async_recover: grant=%b after %0d required %b after 2", grant, n, onehot(w));
        end
        req = 2'b00;
        tick();
        tick();
        $display("[TB] async_reset: recovered, winner=%0d", w);
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_drain_hold();
        test_lock();
        test_random();
        test_violation();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
